ahb_apb_bridge_mp: RTL and testbench
====================================

Name: ahb_apb_bridge_mp

Overview:
Parametrised AHB-to-APB bridge (APB3) serving NUM_SLAVES peripherals in contiguous equal-size address regions above BASE_ADDR. Next generation of the single-module bridge top:
- configurable data/address width and slave count
- PREADY wait states, registered read-data return to AHB
- decode-miss handling
- optional PSLVERR-to-AHB-ERROR mapping

Sits between the AHB fabric (Hreadyout looped back to Hreadyin) and the APB peripheral bus.

Parameters:
ADDR_W, 32, AHB/APB address width
DATA_W, 32, data width (8..64)
NUM_SLAVES, 4, APB select lines (1..16)
BASE_ADDR, 32'h8000_0000, start of slave 0 region; aligned to 2^REGION_BITS
REGION_BITS, 12, log2 of region size per slave

Ports:
Hclk  in  1  clock, all logic on rising edge
Hreset  in  1  synchronous, active-high reset
Hwrite  in  1  AHB direction, 1 = write
Hreadyin  in  1  AHB bus ready
Htrans  in  2  AHB transfer type; NONSEQ=2, SEQ=3 valid; IDLE/BUSY ignored
Haddr  in  ADDR_W  AHB address
Hwdata  in  DATA_W  AHB write data (data phase)
Hrdata  out  DATA_W  registered read data
Hreadyout  out  1  transfer done / slave ready
Hresp  out  1  0 = OKAY, 1 = ERROR
Prdata  in  DATA_W  APB read data
Pready  in  1  APB ready
Pslverr  in  1  APB slave error
Pselx  out  NUM_SLAVES  one-hot APB select
Penable  out  1  APB access phase
Pwrite  out  1  APB direction
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data

Behaviour:
- Reset (Hreset=1 at an edge, any state): state IDLE; Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hrdata=0, Hresp=0, Hreadyout=1. Mid-transfer reset aborts APB at that edge; Psel drops with no completion.
- valid = Hreadyin & Htrans[1]. Sampled only in IDLE and ERR2.
- hit = BASE_ADDR <= Haddr < BASE_ADDR + (NUM_SLAVES<<REGION_BITS). Slot = (Haddr-BASE_ADDR)>>REGION_BITS.
- On valid+hit: Paddr<=Haddr, Pwrite<=Hwrite, slot latched. Next state = WWAIT if write, else SETUP.
- On valid & !hit: state ERR1; no APB activity.
- States and outputs:
  - IDLE: Hreadyout=1, Hresp=0.
  - WWAIT: Hreadyout=0; Pwdata<=Hwdata; next SETUP.
  - SETUP: Pselx[slot]=1, Penable=0, Hreadyout=0; next ACCESS.
  - ACCESS: Pselx[slot]=1, Penable=1, Hreadyout=0. While Pready=0, hold; Paddr/Pwdata/Pwrite stable. On Pready=1: Hrdata<=Prdata (reads only), Psel and Penable low next cycle. Next ERR1 if (Pslverr & ERR_RESP_EN), else IDLE.
  - ERR1: Hreadyout=0, Hresp=1; next ERR2.
  - ERR2: Hreadyout=1, Hresp=1; next IDLE, or accepts a new valid address exactly as IDLE.
- Latency with zero APB wait states, counted as low-Hreadyout cycles: read = 2 (SETUP, ACCESS); write = 3 (WWAIT, SETUP, ACCESS). Each Pready=0 cycle adds 1.
- Back-to-back: an address sampled in the completing IDLE cycle starts the next transfer. No idle APB cycle beyond the mandatory SETUP.
- Hrdata holds its last value until the next read completes.
- Decode miss without ERR_RESP_EN: no ERR states. IDLE stays (OKAY, Hreadyout=1); reads return the held Hrdata; writes are dropped.
- Pselx never has more than one bit set; Penable=1 only while Pselx!=0.

Optional Feature:
ERR_RESP_EN
- Defined: Pslverr sampled with Pready=1, or a decode miss, produces the two-cycle AHB ERROR response (ERR1, ERR2). Hrdata is still updated on an errored read.
- Undefined: Pslverr ignored, Hresp tied 0, ERR1/ERR2 not synthesised, decode miss behaves as described above.

Test Plan:
- Reset: hold Hreset 2 cycles mid-ACCESS -> next cycle Pselx=0, Penable=0, Hreadyout=1, Hrdata=0, Hresp=0.
- Read, zero wait: Haddr=32'h8000_1010 NONSEQ read, Prdata=32'hCAFE_0001, Pready=1 -> Pselx=4'b0010 for 2 cycles, Penable only in 2nd; Hreadyout low 2 cycles; Hrdata=32'hCAFE_0001.
- Write, 3 wait states: Haddr=32'h8000_3004, Hwdata=32'hA5A5_5A5A, Pready low 3 ACCESS cycles -> Pselx=4'b1000; Pwrite=1; Pwdata/Paddr stable throughout; Hreadyout low 6 cycles.
- Back-to-back: write 32'h8000_0000 then read 32'h8000_2000 with Hreadyin=Hreadyout -> Pselx 0001 then 0100; exactly one non-selected cycle between transfers.
- Decode miss: Haddr=32'h8000_4000 write -> Pselx stays 0. With ERR_RESP_EN: Hresp=1 for 2 cycles, Hreadyout 0 then 1. Without ERR_RESP_EN: Hreadyout stays 1, Hresp=0.
- Slave error (ERR_RESP_EN): read 32'h8000_0008, Pslverr=1 with Pready=1 -> ERR1/ERR2 response, Hrdata updated, state IDLE after.

Source files
------------

// File: rtl/ahb_apb_bridge_mp.sv
// AHB-to-APB3 bridge for NUM_SLAVES equal-size regions above BASE_ADDR.
// Define ERR_RESP_EN to map PSLVERR and decode misses onto the two-cycle AHB ERROR response.
module ahb_apb_bridge_mp #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLAVES  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_BITS = 12
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  input  logic                  Hwrite,
  input  logic                  Hreadyin,
  input  logic [1:0]            Htrans,
  input  logic [ADDR_W-1:0]     Haddr,
  input  logic [DATA_W-1:0]     Hwdata,
  output logic [DATA_W-1:0]     Hrdata,
  output logic                  Hreadyout,
  output logic                  Hresp,
  input  logic [DATA_W-1:0]     Prdata,
  input  logic                  Pready,
  input  logic                  Pslverr,
  output logic [NUM_SLAVES-1:0] Pselx,
  output logic                  Penable,
  output logic                  Pwrite,
  output logic [ADDR_W-1:0]     Paddr,
  output logic [DATA_W-1:0]     Pwdata
);

  localparam int SLOT_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NUM_SLAVES) << REGION_BITS;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WWAIT  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
`ifdef ERR_RESP_EN
  localparam logic [2:0] ST_ERR1   = 3'd4;
  localparam logic [2:0] ST_ERR2   = 3'd5;
`endif

  logic [2:0]            state;
  logic [SLOT_W-1:0]     slot;
  logic [SLOT_W-1:0]     slot_dec;
  logic [NUM_SLAVES-1:0] slot_sel;
  logic [ADDR_W-1:0]     offset;
  logic                  valid;
  logic                  hit;
  logic                  sample;
  logic                  accept;

  // The region compare is done on the offset so a top region touching the end of
  // the address space still decodes correctly.
  assign valid    = Hreadyin & Htrans[1];
  assign offset   = Haddr - BASE_ADDR;
  assign hit      = (Haddr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign slot_dec = SLOT_W'(offset >> REGION_BITS);
  assign slot_sel = NUM_SLAVES'(1) << slot;

`ifdef ERR_RESP_EN
  assign sample = (state == ST_IDLE) || (state == ST_ERR2);
`else
  assign sample = (state == ST_IDLE);
`endif
  assign accept = sample & valid & hit;

`ifdef ERR_RESP_EN
  logic unused_inputs;
  assign unused_inputs = Htrans[0];
`else
  logic unused_inputs;
  assign unused_inputs = Htrans[0] ^ Pslverr;
`endif

  // A new address accepted in IDLE/ERR2 overrides the default return to IDLE.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state  <= ST_IDLE;
      slot   <= '0;
      Paddr  <= '0;
      Pwrite <= 1'b0;
      Pwdata <= '0;
      Hrdata <= '0;
    end else begin
      case (state)
        ST_WWAIT: begin
          Pwdata <= Hwdata;
          state  <= ST_SETUP;
        end
        ST_SETUP: state <= ST_ACCESS;
        ST_ACCESS: begin
          if (Pready) begin
            if (!Pwrite) Hrdata <= Prdata;
`ifdef ERR_RESP_EN
            state <= Pslverr ? ST_ERR1 : ST_IDLE;
`else
            state <= ST_IDLE;
`endif
          end
        end
`ifdef ERR_RESP_EN
        ST_ERR1: state <= ST_ERR2;
`endif
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
        slot   <= slot_dec;
        state  <= Hwrite ? ST_WWAIT : ST_SETUP;
      end
`ifdef ERR_RESP_EN
      else if (sample && valid && !hit) begin
        state <= ST_ERR1;
      end
`endif
    end
  end

  always_comb begin
    Pselx     = '0;
    Penable   = 1'b0;
    Hreadyout = 1'b0;
    Hresp     = 1'b0;
    case (state)
      ST_IDLE:   Hreadyout = 1'b1;
      ST_SETUP:  Pselx = slot_sel;
      ST_ACCESS: begin
        Pselx   = slot_sel;
        Penable = 1'b1;
      end
`ifdef ERR_RESP_EN
      ST_ERR1:   Hresp = 1'b1;
      ST_ERR2: begin
        Hreadyout = 1'b1;
        Hresp     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always @(posedge Hclk) begin
    if (!Hreset) begin
      a_psel_onehot: assert ($onehot0(Pselx));
      a_penable_sel: assert (!Penable || (Pselx != '0));
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// Self-checking bench for ahb_apb_bridge_mp: directed vector table, mid-access reset,
// then random transfers against a memory/latency reference model.
module tb_ahb_apb_bridge_mp;

`ifdef ERR_RESP_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        Hclk;
  logic        Hreset;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Hrdata;
  logic        Hreadyout;
  logic        Hresp;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] slave_mem [64];
  logic [31:0] ref_mem   [64];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    bit          serr;
    logic [3:0]  psel;
    int          low;
    logic [31:0] hrdata;
    bit          hresp;
  } vec_t;

  vec_t vecs [10];

  ahb_apb_bridge_mp #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4),
    .BASE_ADDR(32'h8000_0000), .REGION_BITS(12)
  ) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Hrdata(Hrdata),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Prdata(Prdata), .Pready(Pready),
    .Pslverr(Pslverr), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata)
  );

  assign Hreadyin = Hreadyout;

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  function automatic int idx(input logic [31:0] a);
    return int'({a[13:12], a[5:2]});
  endfunction

  task automatic finishTest();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    Htrans = 2'b00;
    repeat (n) @(negedge Hclk);
  endtask

  // Entered at a negedge with Hreadyout=1; acts as AHB master and APB slave for one transfer.
  task automatic applyStimulus(input string name, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int waits, input bit serr,
                               input logic [3:0] exp_psel, input int exp_low,
                               input logic [31:0] exp_hrdata, input bit exp_hresp);
    int   low = 0, nsel = 0, setup_cnt = 0, sel_cnt = 0, wcnt = 0;
    bit   done = 0, stable_bad = 0, en_bad = 0, end_hresp = 0;
    logic [3:0] seen_psel = '0;
    int   sel_exp;
    Htrans = 2'b10;
    Haddr  = addr;
    Hwrite = wr;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge Hclk);
      if (c == 0) begin
        Htrans = 2'b00;
        Hwdata = wr ? wdata : $urandom;
      end
      Pready  = 1'b0;
      Pslverr = 1'b0;
      if (Hreadyout) begin
        done      = 1;
        end_hresp = Hresp;
        nsel++;
        seen_psel = seen_psel | Pselx;
        if (Penable) en_bad = 1;
      end else begin
        low++;
        if (Pselx == 4'b0000) begin
          nsel++;
          if (Penable) en_bad = 1;
        end else begin
          sel_cnt++;
          seen_psel = seen_psel | Pselx;
          if (Paddr !== addr || Pwrite !== wr || (wr && Pwdata !== wdata)) stable_bad = 1;
          if (!Penable) setup_cnt++;
          else if (wcnt == waits) begin
            Pready  = 1'b1;
            Pslverr = serr;
            if (Pwrite) begin
              slave_mem[idx(Paddr)] = Pwdata;
              Prdata = $urandom;
            end else begin
              Prdata = slave_mem[idx(Paddr)];
            end
          end else begin
            wcnt++;
            Prdata = $urandom;
          end
        end
      end
    end
    if (!done) begin
      checkOutput({name, " timeout"}, 32'd0, 32'd1);
      finishTest();
    end
    sel_exp = (exp_psel != 4'b0000) ? waits + 2 : 0;
    checkOutput({name, " latency"}, low, exp_low);
    checkOutput({name, " pselx"}, {28'd0, seen_psel}, {28'd0, exp_psel});
    checkOutput({name, " selected cycles"}, sel_cnt, sel_exp);
    checkOutput({name, " setup cycles"}, setup_cnt, (exp_psel != 4'b0000) ? 1 : 0);
    checkOutput({name, " unselected cycles"}, nsel, exp_low + 1 - sel_exp);
    checkOutput({name, " apb stable"}, {31'd0, stable_bad}, 32'd0);
    checkOutput({name, " penable w/o psel"}, {31'd0, en_bad}, 32'd0);
    checkOutput({name, " hresp"}, {31'd0, end_hresp}, {31'd0, exp_hresp});
    checkOutput({name, " hrdata"}, Hrdata, exp_hrdata);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    failures++;
    finishTest();
  end

  initial begin
    bit          wr, miss, serr;
    int          slot, word, waits, exp_low;
    logic [31:0] addr, wdata, exp_hr;
    logic [3:0]  exp_psel;

    Hreset = 1'b1; Htrans = 2'b00; Haddr = '0; Hwrite = 1'b0; Hwdata = '0;
    Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
    for (int i = 0; i < 64; i++) begin
      slave_mem[i] = $urandom;
      ref_mem[i]   = slave_mem[i];
    end

    vecs[0] = '{1'b0, 32'h8000_1010, 32'hCAFE_0001, 0, 1'b0, 4'b0010, 2, 32'hCAFE_0001, 1'b0};
    vecs[1] = '{1'b1, 32'h8000_3004, 32'hA5A5_5A5A, 3, 1'b0, 4'b1000, 6, 32'hCAFE_0001, 1'b0};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h1234_5678, 0, 1'b0, 4'b0001, 3, 32'hCAFE_0001, 1'b0};
    vecs[3] = '{1'b0, 32'h8000_2000, 32'h0BAD_F00D, 0, 1'b0, 4'b0100, 2, 32'h0BAD_F00D, 1'b0};
    vecs[4] = '{1'b1, 32'h8000_4000, 32'hDEAD_BEEF, 0, 1'b0, 4'b0000, int'(ERR), 32'h0BAD_F00D, ERR};
    vecs[5] = '{1'b0, 32'h7FFF_FFFC, 32'h5555_AAAA, 0, 1'b0, 4'b0000, int'(ERR), 32'h0BAD_F00D, ERR};
    vecs[6] = '{1'b0, 32'h8000_0008, 32'h1111_2222, 1, 1'b1, 4'b0001, 3 + int'(ERR), 32'h1111_2222, ERR};
    vecs[7] = '{1'b0, 32'h8000_1FFC, 32'h7777_0001, 2, 1'b0, 4'b0010, 4, 32'h7777_0001, 1'b0};
    vecs[8] = '{1'b0, 32'h8000_3FFC, 32'h3333_FFFC, 0, 1'b0, 4'b1000, 2, 32'h3333_FFFC, 1'b0};
    vecs[9] = '{1'b1, 32'h8000_2FFC, 32'h0000_0001, 1, 1'b1, 4'b0100, 4 + int'(ERR), 32'h3333_FFFC, ERR};

    repeat (3) @(negedge Hclk);
    checkOutput("reset pselx", {28'd0, Pselx}, 32'd0);
    checkOutput("reset penable", {31'd0, Penable}, 32'd0);
    checkOutput("reset hreadyout", {31'd0, Hreadyout}, 32'd1);
    checkOutput("reset hresp", {31'd0, Hresp}, 32'd0);
    checkOutput("reset hrdata", Hrdata, 32'd0);
    checkOutput("reset paddr", Paddr, 32'd0);
    checkOutput("reset pwdata", Pwdata, 32'd0);
    checkOutput("reset pwrite", {31'd0, Pwrite}, 32'd0);
    Hreset = 1'b0;

    // Directed table, issued back-to-back.
    for (int i = 0; i < 10; i++) begin
      if (!vecs[i].wr) begin
        slave_mem[idx(vecs[i].addr)] = vecs[i].data;
        ref_mem[idx(vecs[i].addr)]   = vecs[i].data;
      end else if (vecs[i].psel != 4'b0000) begin
        ref_mem[idx(vecs[i].addr)] = vecs[i].data;
      end
      applyStimulus($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
                    vecs[i].waits, vecs[i].serr, vecs[i].psel, vecs[i].low,
                    vecs[i].hrdata, vecs[i].hresp);
    end
    idleCycles(2);

    // Reset asserted for two cycles while a read sits in ACCESS with Pready low.
    Htrans = 2'b10; Haddr = 32'h8000_1000; Hwrite = 1'b0;
    @(negedge Hclk);
    Htrans = 2'b00; Pready = 1'b0;
    @(negedge Hclk);
    checkOutput("pre-reset penable", {31'd0, Penable}, 32'd1);
    Hreset = 1'b1;
    @(negedge Hclk);
    checkOutput("mid reset pselx", {28'd0, Pselx}, 32'd0);
    checkOutput("mid reset penable", {31'd0, Penable}, 32'd0);
    checkOutput("mid reset hreadyout", {31'd0, Hreadyout}, 32'd1);
    checkOutput("mid reset hrdata", Hrdata, 32'd0);
    checkOutput("mid reset hresp", {31'd0, Hresp}, 32'd0);
    @(negedge Hclk);
    Hreset = 1'b0;
    exp_hr = 32'd0;

    // Random traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      wr    = 1'($urandom_range(0, 1));
      miss  = ($urandom_range(0, 7) == 0);
      slot  = $urandom_range(0, 3);
      word  = $urandom_range(0, 1023);
      waits = $urandom_range(0, 3);
      serr  = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      if (miss)
        addr = ($urandom_range(0, 1) == 1) ? 32'h8000_4000 + 32'(word * 4)
                                          : 32'h7FFF_F000 + 32'(word * 4);
      else
        addr = 32'h8000_0000 + 32'(slot * 4096) + 32'(word * 4);
      exp_psel = miss ? 4'b0000 : 4'(1 << slot);
      exp_low  = miss ? int'(ERR) : 2 + int'(wr) + waits + int'(ERR && serr);
      if (!miss && !wr) exp_hr = ref_mem[idx(addr)];
      if (!miss && wr)  ref_mem[idx(addr)] = wdata;
      applyStimulus($sformatf("rnd%0d", n), wr, addr, wdata, waits, serr,
                    exp_psel, exp_low, exp_hr, ERR && (miss || serr));
      idleCycles($urandom_range(0, 2));
    end

    finishTest();
  end

endmodule
